fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer_pkg.sv | 15 +
 rtl/fetch_buffer_if.sv | 25 ++
 rtl/fetch_buffer_queue.sv | 37 +++
 rtl/fetch_buffer.sv | 69 ++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared fetch-packet type, sizing constants and word-select helper (package FetchBufferST)
package FetchBufferST;
  localparam int FETCH_WORDS = 4;
  localparam int WORD_BITS = 32;
  localparam int PACKET_BITS = FETCH_WORDS * WORD_BITS;
  localparam int PC_BITS = 64;
  typedef struct packed {
    logic [PACKET_BITS-1:0] data;
    logic [PC_BITS-1:0]     pc;
    logic [1:0]             start;
  } FetchPacketST;
  function automatic logic [WORD_BITS-1:0] word_of(input logic [PACKET_BITS-1:0] d, input logic [1:0] i);
    return d[{i, 5'd0} +: WORD_BITS];
  endfunction
endpackage

// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: ICache-side enqueue, decode-side dequeue, flush and occupancy signals
interface fetch_buffer_if #(
  parameter int DEPTH = 4,
  parameter int VADDR_BITS = 39
);
  logic                    io_enq_valid;
  logic [127:0]            io_enq_bits_data;
  logic [VADDR_BITS-1:0]   io_enq_bits_pc;
  logic                    io_enq_ready;
  logic                    io_drop;
  logic                    io_deq_valid;
  logic                    io_deq_ready;
  logic [31:0]             io_deq_bits_inst;
  logic [VADDR_BITS-1:0]   io_deq_bits_pc;
  logic                    io_flush;
  logic [$clog2(DEPTH):0]  io_count;
  modport master (
    output io_enq_valid, io_enq_bits_data, io_enq_bits_pc, io_deq_ready, io_flush,
    input  io_enq_ready, io_drop, io_deq_valid, io_deq_bits_inst, io_deq_bits_pc, io_count
  );
  modport slave (
    input  io_enq_valid, io_enq_bits_data, io_enq_bits_pc, io_deq_ready, io_flush,
    output io_enq_ready, io_drop, io_deq_valid, io_deq_bits_inst, io_deq_bits_pc, io_count
  );
endinterface

// File: rtl/fetch_buffer_queue.sv
// fetch_packet_queue: DEPTH-entry circular FIFO of fetch packets, flush/reset clear pointers and count
module fetch_packet_queue
  import FetchBufferST::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  FetchPacketST           push_pkt,
  output FetchPacketST           head,
  output FetchPacketST           next,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  FetchPacketST mem [DEPTH];
  logic [AW-1:0] hptr, tptr;
  assign head = mem[hptr];
  assign next = mem[hptr + 1'b1];
  // packet storage needs no reset: nothing is read while count is zero
  always_ff @(posedge clock)
    if (push) mem[tptr] <= push_pkt;
  // pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clock)
    if (reset || flush) begin
      hptr <= '0;
      tptr <= '0;
      count <= '0;
    end else begin
      tptr <= tptr + AW'(push);
      hptr <= hptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: packet FIFO sequenced into 32-bit instructions; FETCH_BUFFER_BYPASS_EN adds empty-buffer enq->deq bypass
module fetch_buffer
  import FetchBufferST::*;
#(
  parameter int DEPTH = 4,
  parameter int VADDR_BITS = 39
) (
  input logic          clock,
  input logic          reset,
  fetch_buffer_if.slave io
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] count;
  FetchPacketST head, next, enq_pkt;
  logic [1:0] widx, widx_n, enq_start;
  logic held, enq_fire, step, pop, push, drop, unused_bits;
  assign held = count != '0;
  assign io.io_enq_ready = count < CW'(DEPTH);
  assign io.io_count = count;
  assign io.io_drop = drop;
  assign enq_fire = io.io_enq_valid && io.io_enq_ready && !io.io_flush;
  assign step = held && io.io_deq_ready;
  assign pop = step && widx == 2'd3;
  assign unused_bits = ^{head, next};
`ifdef FETCH_BUFFER_BYPASS_EN
  logic byp, byp_take;
  assign byp = !held && enq_fire;
  assign byp_take = byp && io.io_deq_ready;
  assign io.io_deq_valid = held || byp;
  assign io.io_deq_bits_inst = held ? word_of(head.data, widx) : byp ? word_of(io.io_enq_bits_data, io.io_enq_bits_pc[3:2]) : '0;
  assign io.io_deq_bits_pc = held ? {head.pc[VADDR_BITS-1:4], widx, 2'b00} : byp ? {io.io_enq_bits_pc[VADDR_BITS-1:2], 2'b00} : '0;
  assign enq_start = io.io_enq_bits_pc[3:2] + 2'(byp_take);
  assign push = enq_fire && !(byp_take && io.io_enq_bits_pc[3:2] == 2'd3);
`else
  assign io.io_deq_valid = held;
  assign io.io_deq_bits_inst = held ? word_of(head.data, widx) : '0;
  assign io.io_deq_bits_pc = held ? {head.pc[VADDR_BITS-1:4], widx, 2'b00} : '0;
  assign enq_start = io.io_enq_bits_pc[3:2];
  assign push = enq_fire;
`endif
  assign enq_pkt = '{data: io.io_enq_bits_data, pc: PC_BITS'(io.io_enq_bits_pc), start: enq_start};
  fetch_packet_queue #(.DEPTH(DEPTH)) queue (
    .clock(clock),
    .reset(reset),
    .flush(io.io_flush),
    .push(push),
    .pop(pop),
    .push_pkt(enq_pkt),
    .head(head),
    .next(next),
    .count(count)
  );
  // word index: step through the head packet, reload start index whenever a new packet becomes head
  always_comb
    widx_n = io.io_flush ? 2'd0
           : pop ? (count > CW'(1) ? next.start : push ? enq_start : 2'd0)
           : step ? widx + 2'd1
           : (!held && push) ? enq_start
           : widx;
  // word index register and one-cycle drop pulse for packets arriving while full
  always_ff @(posedge clock)
    if (reset) begin
      widx <= 2'd0;
      drop <= 1'b0;
    end else begin
      widx <= widx_n;
      drop <= io.io_enq_valid && !io.io_enq_ready && !io.io_flush;
    end
endmodule
